sa_feed_sequencer: RTL and testbench
====================================

// Module: sa_feed_sequencer
// PURPOSE
//  Sequences one bank of operand serializers (one per systolic-array lane) per tile.
//  Loads every lane in one cycle, then releases lanes on a diagonal skew.
//    Lane i starts shifting i cycles after lane 0, forming the wavefront the array needs.
//  After the last lane empties, waits a fixed drain time for the array pipeline, then signals done.
//  Two instances are used: one for the row-operand bank, one for the column-operand bank.
// PARAMETERS
//  N_LANES      32  serializers driven; lane 0 has no skew
//  LENGTH       32  words per serializer (equals the serializer LENGTH)
//  DRAIN_CYCLES 32  idle cycles after streaming, before done (>=1)
//  CW           8   step counter width; must hold LENGTH+N_LANES-1
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        begin a tile; sampled only in IDLE
//  busy        out  1        high in every state except IDLE
//  done        out  1        one-cycle pulse in the DONE state
//  wr_en       out  N_LANES  per-lane serializer write_enable (load)
//  rd_en       out  N_LANES  per-lane serializer read_enable (shift)
//  lane_valid  out  N_LANES  lane i's serializer output carries a live word this cycle
//  step        out  CW       STREAM cycle index t (0 outside STREAM)
//  tile_count  out  16       completed tiles; wraps at 2^16
// BEHAVIOUR
//  Outputs are Moore decodes of the registered state and counters; no combinational path from start.
//  Reset (async assert, sync release):
//    state=IDLE; counters=0; busy=done=0; wr_en=rd_en=lane_valid=0; step=0; tile_count=0.
//  Reset mid-tile aborts immediately with the same values.
//    Serializer contents are don't-care afterwards.
//  FSM:
//    IDLE   start=1 -> LOAD; otherwise stay.
//    LOAD   1 cycle; wr_en=all ones; rd_en=0 -> STREAM with t=0.
//    STREAM t runs 0..LENGTH+N_LANES-2, incrementing once per cycle.
//           For lane i: rd_en[i]=lane_valid[i]=(i<=t && t<i+LENGTH).
//           wr_en=0. After the last t -> DRAIN.
//    DRAIN  DRAIN_CYCLES cycles, all enables 0 -> DONE.
//    DONE   1 cycle; done=1; tile_count++ -> IDLE.
//  Data order: after LOAD, the serializer outputs its top word (index LENGTH-1).
//    The shift at the end of each rd_en cycle exposes the next word down.
//    So lane i presents word LENGTH-1-k at t=i+k, for k=0..LENGTH-1.
//  Enable rules:
//    wr_en and rd_en are never both high on a lane; the serializer treats that as hold.
//    A lane never sees more than LENGTH rd_en cycles per tile.
//  Per-tile latency: the start-accept cycle plus 1 LOAD, (LENGTH+N_LANES-1) STREAM,
//    DRAIN_CYCLES DRAIN and 1 DONE cycle.
//    done is high exactly LENGTH+N_LANES+DRAIN_CYCLES+1 cycles after the start-accept cycle.
//  start while busy: ignored, not queued.
//    start held high continuously re-arms only on return to IDLE, giving one idle cycle between tiles.
//  Counter widths: step saturates never; CW too small is a parameter error.
//    Elaboration asserts (1<<CW) > LENGTH+N_LANES-1 and DRAIN_CYCLES>=1.
//  Drain counter is independent of step; both clear on entry to STREAM and DRAIN respectively.
// TESTING (N_LANES=4, LENGTH=4, DRAIN_CYCLES=3, CW=4 unless noted)
//  Reset, idle 5 cycles -> busy=done=0, enables 0, tile_count=0.
//  start pulse at cycle 0:
//    -> wr_en=4'b1111 at cycle 1.
//    -> rd_en: 0001,0011,0111,1111,1110,1100,1000 on cycles 2-8.
//    -> done at cycle 12; tile_count=1.
//  Load lane i with words {i3,i2,i1,i0} into real serialize instances:
//    -> lane 2 outputs i3,i2,i1,i0 on t=2..5 while lane_valid[2]=1.
//  start re-pulsed during STREAM and DRAIN -> ignored; exactly one done; next tile only after IDLE.
//  rst_n low at t=3 of STREAM -> all outputs 0 asynchronously.
//    -> After release, a fresh start gives the full sequence again; tile_count stays 0.
//  start held high for 3 tiles -> 3 done pulses 13 cycles apart; tile_count 0xFFFF wraps to 0 (preload via force).

Source files
------------

// File: rtl/sa_feed_if.sv
// sa_feed_if: control/enable bundle between a tile sequencer and its serializer bank.
interface sa_feed_if #(
  parameter int N_LANES = 32,
  parameter int CW      = 8
);
  logic               start;
  logic               busy;
  logic               done;
  logic [N_LANES-1:0] wr_en;
  logic [N_LANES-1:0] rd_en;
  logic [N_LANES-1:0] lane_valid;
  logic [CW-1:0]      step;
  logic [15:0]        tile_count;
  modport master (input start, output busy, done, wr_en, rd_en, lane_valid, step, tile_count);
  modport slave  (output start, input busy, done, wr_en, rd_en, lane_valid, step, tile_count);
endinterface

// File: rtl/sa_feed_sequencer.sv
// sa_feed_sequencer: loads a serializer bank, releases lanes on a diagonal skew, drains, pulses done.
module sa_feed_sequencer #(
  parameter int N_LANES      = 32,
  parameter int LENGTH       = 32,
  parameter int DRAIN_CYCLES = 32,
  parameter int CW           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sa_feed_if.master   bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(LENGTH + N_LANES - 2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);
  if (!((1 << CW) > LENGTH + N_LANES - 1)) $error("CW too small for LENGTH+N_LANES-1");
  if (DRAIN_CYCLES < 1) $error("DRAIN_CYCLES must be >= 1");
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] t;
  logic [DW-1:0] dc;
  logic [15:0]   tile_cnt;
  logic [N_LANES-1:0] win;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      dc       <= '0;
      tile_cnt <= '0;
    end else begin
      state    <= nxt;
      t        <= (state == STREAM && nxt == STREAM) ? t + 1'b1 : '0;
      dc       <= (state == DRAIN && nxt == DRAIN) ? dc + 1'b1 : '0;
      tile_cnt <= tile_cnt + 16'(state == DONE);
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = STREAM;
      STREAM:  nxt = (t == T_LAST) ? DRAIN : STREAM;
      DRAIN:   nxt = (dc == D_LAST) ? DONE : DRAIN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // lane i is live for t in [i, i+LENGTH)
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign win[i] = (state == STREAM) && (t >= CW'(i)) && (t < CW'(i + LENGTH));
  end
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.wr_en      = {N_LANES{state == LOAD}};
  assign bus.rd_en      = win;
  assign bus.lane_valid = win;
  assign bus.step       = t;
  assign bus.tile_count = tile_cnt;
endmodule

// File: tb/tb_sa_feed_sequencer.sv
// tb_sa_feed_sequencer: directed vectors against a phase-based tile model and a bench-side serializer bank.
module tb_sa_feed_sequencer;
  localparam int N = 4, L = 4, D = 3, CW = 4;
  localparam int TOT = L + N + D + 1;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  sa_feed_if #(.N_LANES(N), .CW(CW)) bus ();
  sa_feed_sequencer #(.N_LANES(N), .LENGTH(L), .DRAIN_CYCLES(D), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  int nvec = 0, nerr = 0;
  int ph = -1;
  logic [15:0] mtiles = 0;
  logic [7:0] mem [N][L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = -1;
      mtiles = 0;
    end else if (ph == -1) begin
      if (bus.start) ph = 1;
    end else if (ph == TOT) begin
      ph = -1;
      mtiles = mtiles + 1;
    end else ph = ph + 1;
  end
  // bench serializers: load words {i,k} at index k, shift down toward index L-1 on rd_en
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.wr_en[i] && !bus.rd_en[i])
        for (int k = 0; k < L; k++) mem[i][k] <= 8'(i * 16 + k);
      else if (bus.rd_en[i] && !bus.wr_en[i])
        for (int k = L - 1; k > 0; k--) mem[i][k] <= mem[i][k-1];
    end
  end
  always @(negedge clk) begin
    int tt;
    logic [N-1:0] er;
    logic [CW-1:0] es;
    logic streaming;
    tt = ph - 2;
    streaming = (ph >= 2 && ph <= L + N);
    for (int i = 0; i < N; i++) er[i] = streaming && i <= tt && tt < i + L;
    es = streaming ? CW'(tt) : '0;
    nvec++;
    if (bus.busy !== (ph >= 1) || bus.done !== (ph == TOT) || bus.wr_en !== {N{ph == 1}} ||
        bus.rd_en !== er || bus.lane_valid !== er || bus.step !== es || bus.tile_count !== mtiles) begin
      nerr++;
      $display("FAIL model ph=%0d: busy=%b done=%b wr=%b rd=%b lv=%b step=%0d tc=%h ; required busy=%b done=%b wr=%b rd=%b step=%0d tc=%h",
        ph, bus.busy, bus.done, bus.wr_en, bus.rd_en, bus.lane_valid, bus.step, bus.tile_count,
        ph >= 1, ph == TOT, {N{ph == 1}}, er, es, mtiles);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [N-1:0] rd_exp [7];
    int dcyc [$];
    int dtc [$];
    int dones;
    rd_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    bus.start = 0;
    cyc(3);
    rst_n = 1;
    cyc(5);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_en", 32'({bus.wr_en, bus.rd_en, bus.done}), 0);
    chk("idle_tc", 32'(bus.tile_count), 0);
    // tile 1: start pulse in cycle 0
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    chk("load_wr", 32'(bus.wr_en), 32'hF);
    for (int c = 2; c <= 8; c++) begin
      cyc(1);
      chk($sformatf("rd_c%0d", c), 32'(bus.rd_en), 32'(rd_exp[c-2]));
      if (c >= 4 && c <= 7) begin
        chk($sformatf("lane2_lv_t%0d", c - 2), 32'(bus.lane_valid[2]), 1);
        chk($sformatf("lane2_word_t%0d", c - 2), 32'(mem[2][L-1]), 32'(8'h20 + 8'(3 - (c - 4))));
      end
    end
    cyc(3);
    chk("done_pre", 32'(bus.done), 0);
    cyc(1);
    chk("done_c12", 32'(bus.done), 1);
    cyc(1);
    chk("tc_1", 32'(bus.tile_count), 1);
    // start re-pulsed during STREAM and DRAIN is ignored
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    dones = 0;
    for (int c = 1; c < 25; c++) begin
      bus.start = (c == 4 || c == 10);
      cyc(1);
      dones += int'(bus.done);
    end
    bus.start = 0;
    chk("one_done", 32'(dones), 1);
    chk("tc_2", 32'(bus.tile_count), 2);
    chk("idle_after", 32'(bus.busy), 0);
    // async reset at t=3 of STREAM
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    cyc(4);
    chk("pre_rst_step", 32'(bus.step), 3);
    #1 rst_n = 0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_en", 32'({bus.wr_en, bus.rd_en, bus.lane_valid}), 0);
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_tc", 32'(bus.tile_count), 0);
    cyc(2);
    rst_n = 1;
    cyc(2);
    bus.start = 1;
    cyc(1);
    bus.start = 0;
    chk("rst_again_wr", 32'(bus.wr_en), 32'hF);
    cyc(11);
    chk("rst_again_done", 32'(bus.done), 1);
    cyc(1);
    chk("rst_again_tc", 32'(bus.tile_count), 1);
    // preload tile_count to 0xFFFF, then hold start for 3 tiles
    cyc(1);
    #2;
    force dut.tile_cnt = 16'hFFFF;
    mtiles = 16'hFFFF;
    @(posedge clk);
    #1 release dut.tile_cnt;
    cyc(1);
    chk("preload_tc", 32'(bus.tile_count), 32'hFFFF);
    bus.start = 1;
    for (int c = 0; c < 60 && dcyc.size() < 3; c++) begin
      cyc(1);
      if (bus.done) begin
        dcyc.push_back(c);
        cyc(1);
        c++;
        dtc.push_back(int'(bus.tile_count));
      end
    end
    bus.start = 0;
    chk("held_dones", 32'(dcyc.size()), 3);
    if (dcyc.size() == 3) begin
      chk("gap1", 32'(dcyc[1] - dcyc[0]), 13);
      chk("gap2", 32'(dcyc[2] - dcyc[1]), 13);
      chk("wrap_tc0", 32'(dtc[0]), 0);
      chk("wrap_tc2", 32'(dtc[2]), 2);
    end
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
